// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_A      = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition evaluation and CondExQ latch
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       capture,
  input  logic       flagwrite_nz,
  input  logic       flagwrite_cv,
  output logic       condexq,
  output logic [3:0] flags
);

  logic n, z, c, v;
  logic condex;

  assign {n, z, c, v} = flags;

  // Evaluate the condition field against the registered flags
  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Latch the condition once per instruction and update flags only when it passed
  always_ff @(posedge clk) begin
    if (reset) begin
      flags   <= 4'b0000;
      condexq <= 1'b0;
    end else begin
      if (capture)
        condexq <= condex;
      if (flagwrite_nz && condexq)
        flags[3:2] <= aluflags[3:2];
      if (flagwrite_cv && condexq)
        flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control FSM and ALU decode
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  state_t     state, state_next;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rd;

  logic [2:0] alu_dec;
  logic       nowrite, supported, cv_cmd;
  logic       is_exec, fw_nz, fw_cv;
  logic       condexq;
  logic [3:0] flags;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign unused_rd = ^{Instr[7:4], flags};
  assign State     = state;
  assign ImmSrc    = op;

  // Map the data-processing command to an ALU operation and its side effects
  always_comb begin
    alu_dec   = ALU_ADD;
    nowrite   = 1'b0;
    supported = 1'b1;
    cv_cmd    = 1'b0;
    case (funct[4:1])
      CMD_ADD: cv_cmd = 1'b1;
      CMD_SUB: begin alu_dec = ALU_SUB; cv_cmd = 1'b1; end
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      CMD_EOR: alu_dec = ALU_EOR;
      CMD_CMP: begin alu_dec = ALU_SUB; cv_cmd = 1'b1; nowrite = 1'b1; end
      default: begin nowrite = 1'b1; supported = 1'b0; end
    endcase
  end

  assign is_exec = (state == EXECUTER) || (state == EXECUTEI);
  assign fw_nz   = is_exec & funct[0] & supported;
  assign fw_cv   = fw_nz & cv_cmd;

  cond_unit u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond         (cond),
    .aluflags     (ALUFlags),
    .capture      (state == DECODE),
    .flagwrite_nz (fw_nz),
    .flagwrite_cv (fw_cv),
    .condexq      (condexq),
    .flags        (flags)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_next;
  end

  // Sequence each instruction class through its state path
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_BR:   state_next = BRANCH;
          OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          default: state_next = FETCH;
        endcase
      end
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      MEMADR:   state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      default:  state_next = FETCH;
    endcase
  end

  // Moore outputs per state; enables are held low while reset is asserted
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = ADR_PC;
    RegSrc     = 2'b00;
    ALUSrcA    = SRCA_A;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
      end
      EXECUTER: ALUControl = alu_dec;
      EXECUTEI: begin ALUSrcB = SRCB_IMM; ALUControl = alu_dec; end
      ALUWB:    RegWrite = condexq & ~nowrite;
      MEMADR:   begin ALUSrcB = SRCB_IMM; RegSrc = 2'b10; end
      MEMRD:    AdrSrc = ADR_ALUOUT;
      MEMWB:    begin ResultSrc = RES_DATA; RegWrite = condexq; end
      MEMWR:    begin AdrSrc = ADR_ALUOUT; RegSrc = 2'b10; MemWrite = condexq; end
      BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT;
        PCWrite = condexq;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, mw, rw, irw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm;
    logic [2:0] alu;
    logic [3:0] flags;
  } rec_t;

  logic        clk, reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  rec_t        exp_q[$];
  rec_t        mon_e, mon_a;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [3:0]  cur_flags;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every presented cycle against the next queued expectation
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
               dut.u_cond.flags};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL cycle%0d state%0d: got %h required %h (st pcw mw rw irw adr rs sa sb res imm alu nzcv)",
                 cyc, mon_e.st, mon_a, mon_e);
      end
    end
  end

  // Expected outputs of one state, from the controller's state table
  function automatic rec_t mk(state_t s, logic [19:0] ins, logic rw, logic mw,
                              logic br, logic [2:0] alu, logic [3:0] fl);
    rec_t r;
    r = '0;
    r.st = s; r.imm = ins[15:14]; r.alu = ALU_ADD; r.flags = fl;
    case (s)
      FETCH:    begin r.pcw = 1; r.irw = 1; r.srca = 2'b01; r.srcb = 2'b10; r.res = 2'b10; end
      DECODE:   begin r.srca = 2'b01; r.srcb = 2'b10; r.res = 2'b10; end
      EXECUTER: r.alu = alu;
      EXECUTEI: begin r.srcb = 2'b01; r.alu = alu; end
      ALUWB:    r.rw = rw;
      MEMADR:   begin r.srcb = 2'b01; r.regsrc = 2'b10; end
      MEMRD:    r.adr = 1;
      MEMWB:    begin r.res = 2'b01; r.rw = rw; end
      MEMWR:    begin r.adr = 1; r.regsrc = 2'b10; r.mw = mw; end
      BRANCH:   begin r.regsrc = 2'b01; r.srcb = 2'b01; r.res = 2'b10; r.pcw = br; end
      default:  ;
    endcase
    return r;
  endfunction

  // Drive one instruction, queueing the expected response of each of its cycles
  task automatic run(input logic [19:0] ins, input logic [3:0] af, input logic rw,
                     input logic mw, input logic br, input logic [2:0] alu,
                     input logic [3:0] nf, input logic rst_last);
    state_t seq[5];
    int     n;
    rec_t   r;
    logic [3:0] fl;
    seq[0] = FETCH; seq[1] = DECODE; seq[2] = FETCH; seq[3] = FETCH; seq[4] = FETCH;
    case (ins[15:14])
      2'b00:   begin seq[2] = ins[13] ? EXECUTEI : EXECUTER; seq[3] = ALUWB; n = 4; end
      2'b01:   begin
        seq[2] = MEMADR;
        if (ins[8]) begin seq[3] = MEMRD; seq[4] = MEMWB; n = 5; end
        else        begin seq[3] = MEMWR; n = 4; end
      end
      2'b10:   begin seq[2] = BRANCH; n = 3; end
      default: n = 2;
    endcase
    Instr = ins;
    for (int c = 0; c < n; c++) begin
      ALUFlags = (seq[c] == EXECUTER || seq[c] == EXECUTEI) ? af : ~af;
      fl = (c >= 3 && ins[15:14] == 2'b00) ? nf : cur_flags;
      r = mk(seq[c], ins, rw, mw, br, alu, fl);
      if (rst_last && c == n - 1) begin
        reset = 1'b1;
        r.pcw = 0; r.mw = 0; r.rw = 0; r.irw = 0;
      end
      exp_q.push_back(r);
      @(posedge clk); #1;
    end
    if (rst_last) begin
      reset = 1'b0;
      cur_flags = 4'b0000;
    end else begin
      cur_flags = nf;
    end
  endtask

  initial begin
    rec_t r;
    reset = 1'b1; Instr = 20'hE0821; ALUFlags = 4'b0000; cur_flags = 4'b0000;
    @(posedge clk); #1;
    r = mk(FETCH, Instr, 0, 0, 0, ALU_ADD, 4'b0000);
    r.pcw = 0; r.irw = 0;
    exp_q.push_back(r);
    @(posedge clk); #1;
    reset = 1'b0;
    //   instr       aluflags rw mw br alu      new flags rst
    run(20'hE0821, 4'b0000, 1, 0, 0, ALU_ADD, 4'b0000, 0); // ADD R1,R2,R3
    run(20'hE5904, 4'b0000, 1, 0, 0, ALU_ADD, 4'b0000, 0); // LDR R4,[R0,#8]
    run(20'hE5804, 4'b0000, 0, 1, 0, ALU_ADD, 4'b0000, 0); // STR R4,[R0,#8]
    run(20'hE0511, 4'b0100, 1, 0, 0, ALU_SUB, 4'b0100, 0); // SUBS
    run(20'h0A000, 4'b0000, 0, 0, 1, ALU_ADD, 4'b0100, 0); // BEQ taken
    run(20'h1A000, 4'b0000, 0, 0, 0, ALU_ADD, 4'b0100, 0); // BNE not taken
    run(20'hE1510, 4'b1001, 0, 0, 0, ALU_SUB, 4'b1001, 0); // CMP R1,R2
    run(20'h08211, 4'b1111, 0, 0, 0, ALU_ADD, 4'b1001, 0); // ADDEQ with Z=0
    run(20'hE0111, 4'b0110, 1, 0, 0, ALU_AND, 4'b0101, 0); // ANDS, C/V held
    run(20'h10511, 4'b1010, 0, 0, 0, ALU_SUB, 4'b0101, 0); // SUBSNE fails, flags held
    run(20'hE1811, 4'b1111, 1, 0, 0, ALU_ORR, 4'b0101, 0); // ORR, no S
    run(20'hE0311, 4'b1100, 1, 0, 0, ALU_EOR, 4'b1101, 0); // EORS
    run(20'hE1111, 4'b0000, 0, 0, 0, ALU_ADD, 4'b1101, 0); // unsupported cmd, S=1
    run(20'hEC000, 4'b0000, 0, 0, 0, ALU_ADD, 4'b1101, 0); // Op=11 no-op
    run(20'hAA000, 4'b0000, 0, 0, 1, ALU_ADD, 4'b1101, 0); // BGE taken (N==V)
    run(20'h8A000, 4'b0000, 0, 0, 0, ALU_ADD, 4'b1101, 0); // BHI not taken (C=0)
    run(20'hE5804, 4'b0000, 0, 1, 0, ALU_ADD, 4'b1101, 1); // STR, reset in MEMWR
    run(20'hEC000, 4'b0000, 0, 0, 0, ALU_ADD, 4'b0000, 0); // no-op after reset
    run(20'hE2821, 4'b0000, 1, 0, 0, ALU_ADD, 4'b0000, 0); // ADD immediate
    @(negedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
